// File: rtl/fetch_ctrl.sv
// Instruction fetch/decode sequencer: requests a word, latches it, classifies it as a
// sequential or control-transfer instruction and issues a single PC write strobe per
// instruction. Every output is decoded from registered state only.
module fetch_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      inst,
    input  logic             zero,
    input  logic             stall,
    output logic [2:0]       pc_src,
    output logic             pc_we,
    output logic [31:0]      ir,
    output logic             ir_valid,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [2:0] SRC_SEQ  = 3'b000;
    localparam logic [2:0] SRC_JR   = 3'b001;
    localparam logic [2:0] SRC_BEQ  = 3'b010;
    localparam logic [2:0] SRC_BNE  = 3'b011;
    localparam logic [2:0] SRC_J    = 3'b100;
    localparam logic [2:0] SRC_HOLD = 3'b111;

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic [2:0]        src_q, src_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [2:0]        dec_src;
    logic              dec_halt;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];

    // Classify the latched instruction; branch outcome folds in the live zero flag,
    // which only gets captured on the cycle DECODE is left.
    always_comb begin
        dec_src  = SRC_SEQ;
        dec_halt = 1'b0;
        case (opcode)
            6'b000000: if (funct == 6'b001000) dec_src = SRC_JR;
            6'b000100: dec_src = zero ? SRC_BEQ : SRC_SEQ;
            6'b000101: dec_src = zero ? SRC_SEQ : SRC_BNE;
            6'b000010: dec_src = SRC_J;
            6'b111111: dec_halt = 1'b1;
            default:   dec_src = SRC_SEQ;
        endcase
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        src_d      = src_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    wait_d     = '0;
                    ir_valid_d = 1'b0;
                end
            end
            S_FETCH: begin
                // Ack wins over the timeout when both land on the same cycle.
                if (imem_ack) begin
                    ir_d       = inst;
                    ir_valid_d = 1'b1;
                    state_d    = S_DECODE;
                end else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (!stall) begin
                    if (dec_halt) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_UPDATE;
                        src_d   = dec_src;
                    end
                end
            end
            S_UPDATE: begin
                state_d    = S_FETCH;
                wait_d     = '0;
                ir_valid_d = 1'b0;
                if (src_q != SRC_SEQ && cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            src_q      <= SRC_SEQ;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        imem_req     = (state_q == S_FETCH);
        pc_we        = (state_q == S_UPDATE);
        pc_src       = (state_q == S_UPDATE) ? src_q : SRC_HOLD;
        halted       = (state_q == S_HALT);
        error        = (state_q == S_ERROR);
        ir           = ir_q;
        ir_valid     = ir_valid_q;
        redirect_cnt = cnt_q;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15: maximum cycles in FETCH awaiting imem_ack before error.
REQ-002 SHALL have parameter CNT_W, default 8: width of redirect_cnt.
REQ-003 SHALL have ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  begin sequencing from IDLE.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid on inst this cycle.
- inst  in  32  fetched instruction word.
- zero  in  1  rs==rt compare result for the latched instruction.
- stall  in  1  hold in DECODE; no PC update.
- pc_src  out  3  PC select: 000 PC+4, 001 JR, 010 BEQ, 011 BNE, 100 J, 111 hold.
- pc_we  out  1  PC write strobe, one cycle per instruction.
- ir  out  32  latched instruction.
- ir_valid  out  1  ir holds a fetched instruction.
- halted  out  1  HALT executed.
- error  out  1  fetch timeout occurred.
- redirect_cnt  out  CNT_W  count of non-sequential PC updates.

Function
REQ-004 SHALL implement states IDLE, FETCH, DECODE, UPDATE, HALT, ERROR.
REQ-005 IDLE SHALL go to FETCH on start=1; otherwise it stays in IDLE.
REQ-006 FETCH SHALL assert imem_req=1 and count wait cycles from 0.
REQ-007 In FETCH, imem_ack=1 SHALL latch inst into ir, set ir_valid=1, and go to DECODE next cycle.
- imem_ack is ignored in all other states.
REQ-008 In FETCH, if the wait count reaches ACK_TIMEOUT without imem_ack, the FSM SHALL go to ERROR and set error=1.
- imem_ack in the same cycle the count reaches ACK_TIMEOUT takes priority; no error.
REQ-009 DECODE SHALL classify ir:
- opcode 000000 with funct 001000 -> JR.
- opcode 000100 -> BEQ.
- opcode 000101 -> BNE.
- opcode 000010 -> J.
- opcode 111111 -> HALT.
- all else -> SEQ.
REQ-010 In DECODE with stall=1, the FSM SHALL stay in DECODE with pc_we=0.
REQ-011 In DECODE with stall=0, the FSM SHALL go to UPDATE, or to HALT for a HALT opcode.
REQ-012 zero SHALL be sampled in the DECODE cycle that leaves DECODE and registered for UPDATE.
REQ-013 UPDATE SHALL assert pc_we=1 for exactly one cycle, then go to FETCH.
REQ-014 pc_src in UPDATE SHALL be:
- SEQ -> 000; JR -> 001; J -> 100.
- BEQ -> 010 if the registered zero=1, else 000.
- BNE -> 011 if the registered zero=0, else 000.
REQ-015 pc_src SHALL be 111 and pc_we 0 in every state other than UPDATE.
REQ-016 redirect_cnt SHALL increment in each UPDATE cycle with pc_src not equal to 000, saturating at all-ones (no wrap).
REQ-017 HALT SHALL set halted=1, keep pc_we=0, and stay in HALT until reset (start ignored).
REQ-018 ERROR SHALL keep error=1, imem_req=0, pc_we=0 until reset.
REQ-019 ir_valid SHALL clear on entry to FETCH; ir keeps its last value.
REQ-020 All outputs SHALL be driven by registered state (Moore); no combinational input-to-output path.

Reset
REQ-021 rst=0 SHALL immediately, regardless of clk, force:
- state IDLE.
- imem_req=0, pc_we=0, pc_src=111.
- ir=0, ir_valid=0, halted=0, error=0, redirect_cnt=0, wait count 0.
REQ-022 Reset asserted mid-FETCH or mid-UPDATE SHALL abort with no pc_we pulse; the first cycle after release is IDLE.

Verification
REQ-023 The bench SHALL cover:
- Sequence: start; ack after 2 cycles with inst=0x20080005 -> ir=0x20080005, one pc_we pulse with pc_src=000, redirect_cnt=0.
- Branches: BEQ 0x1109FFFE with zero=1 -> pc_src=010, cnt+1; same with zero=0 -> 000; BNE 0x1509FFFE with zero=0 -> 011.
- J and JR: J 0x08000010 -> 100; JR 0x03E00008 -> 001; stall=1 for 3 cycles first -> pc_we stays 0 for those 3 cycles, then one pulse.
- Timeout: no imem_ack for 15 cycles -> error=1, imem_req=0; ack in cycle 15 -> no error.
- Halt/saturation: inst 0xFC000000 -> halted=1, no further imem_req; CNT_W=2 with 5 taken jumps -> redirect_cnt=3.
- Async reset: rst=0 between clock edges during UPDATE -> pc_we drops immediately, all outputs at reset values.
